// File: rtl/fifo_rd_ctrl.sv
// Read-side control for the dual-clock FIFO: read pointers, empty/almost-empty, underflow, read-valid.
// Optional macro FIFO_RD_LEVEL_EN adds the rd_level output and a level-based almost_empty.
module fifo_rd_ctrl #(
    parameter int ADDR_W          = 4,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_rd_en,
    input  logic              i_err_clr,
    input  logic [ADDR_W:0]   i_rq2_wptr,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic [ADDR_W:0]   o_rd_ptr,
    output logic              o_rd_valid,
    output logic              o_empty,
    output logic              o_almost_empty,
    output logic              o_underflow_err
`ifdef FIFO_RD_LEVEL_EN
    ,
    output logic [ADDR_W:0]   o_rd_level
`endif
);

    logic [ADDR_W:0] r_rbin;
    logic [ADDR_W:0] r_rd_ptr;
    logic            r_empty;
    logic            r_rd_valid;
    logic            r_underflow_err;

    logic [ADDR_W:0] w_rbin_next;
    logic [ADDR_W:0] w_gray_next;
    logic            w_rd_accept;
    logic            w_underflow;

    function automatic logic [ADDR_W:0] bin2gray(input logic [ADDR_W:0] b);
        return b ^ (b >> 1);
    endfunction

    assign w_rd_accept = i_rd_en & ~r_empty;
    assign w_underflow = i_rd_en & r_empty;
    assign w_rbin_next = r_rbin + {{ADDR_W{1'b0}}, w_rd_accept};
    assign w_gray_next = bin2gray(w_rbin_next);

    // Empty compares next Gray pointer against the synchronized write pointer as sampled this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rbin          <= '0;
            r_rd_ptr        <= '0;
            r_empty         <= 1'b1;
            r_rd_valid      <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            r_rbin     <= w_rbin_next;
            r_rd_ptr   <= w_gray_next;
            r_empty    <= (w_gray_next == i_rq2_wptr);
            r_rd_valid <= w_rd_accept;
            if (w_underflow) begin
                r_underflow_err <= 1'b1;
            end else if (i_err_clr) begin
                r_underflow_err <= 1'b0;
            end
        end
    end

    assign o_rd_addr       = r_rbin[ADDR_W-1:0];
    assign o_rd_ptr        = r_rd_ptr;
    assign o_rd_valid      = r_rd_valid;
    assign o_empty         = r_empty;
    assign o_underflow_err = r_underflow_err;

`ifdef FIFO_RD_LEVEL_EN
    localparam logic [ADDR_W:0] AE_TH = (ADDR_W+1)'(ALMOST_EMPTY_TH);

    logic [ADDR_W:0] w_wbin;
    logic [ADDR_W:0] w_level;
    logic [ADDR_W:0] r_rd_level;
    logic            r_almost_empty;

    function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Level wraps modulo 2**(ADDR_W+1); the extra MSB keeps a full FIFO distinct from empty.
    assign w_wbin  = gray2bin(i_rq2_wptr);
    assign w_level = w_wbin - w_rbin_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_level     <= '0;
            r_almost_empty <= 1'b1;
        end else begin
            r_rd_level     <= w_level;
            r_almost_empty <= (w_level <= AE_TH);
        end
    end

    assign o_rd_level     = r_rd_level;
    assign o_almost_empty = r_almost_empty;
`else
    assign o_almost_empty = r_empty;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl (ADDR_W=4, ALMOST_EMPTY_TH=2); covers FIFO_RD_LEVEL_EN when defined.
module tb_fifo_rd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rd_en = 1'b0;
    logic       err_clr = 1'b0;
    logic [4:0] rq2_wptr = '0;
    logic [3:0] rd_addr;
    logic [4:0] rd_ptr;
    logic       rd_valid;
    logic       empty;
    logic       almost_empty;
    logic       underflow_err;
`ifdef FIFO_RD_LEVEL_EN
    logic [4:0] rd_level;
`endif

    always #5 clk = ~clk;

    fifo_rd_ctrl #(.ADDR_W(4), .ALMOST_EMPTY_TH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_rd_en        (rd_en),
        .i_err_clr      (err_clr),
        .i_rq2_wptr     (rq2_wptr),
        .o_rd_addr      (rd_addr),
        .o_rd_ptr       (rd_ptr),
        .o_rd_valid     (rd_valid),
        .o_empty        (empty),
        .o_almost_empty (almost_empty),
        .o_underflow_err(underflow_err)
`ifdef FIFO_RD_LEVEL_EN
        ,
        .o_rd_level     (rd_level)
`endif
    );

    typedef struct {
        logic       empty;
        logic       ae;
        logic [3:0] addr;
        logic [4:0] ptr;
        logic       valid;
        logic       err;
        logic [4:0] level;
    } exp_t;

    typedef struct {
        logic       rd_en;
        logic       clr;
        logic [4:0] wptr;
        exp_t       e;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    // reference model state
    int   m_rbin;
    logic m_empty;
    logic m_err;
    logic m_valid;
    int   m_level;
    int   m_reads;

    function automatic int gray2bin(input logic [4:0] g);
        for (int b = 0; b < 32; b++) begin
            if (5'((b ^ (b >> 1))) == g) return b;
        end
        return 0;
    endfunction

    function automatic logic [4:0] bin2gray(input int b);
        return 5'(b ^ (b >> 1));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rbin = 0; m_empty = 1'b1; m_err = 1'b0; m_valid = 1'b0; m_level = 0;
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        e.empty = m_empty;
`ifdef FIFO_RD_LEVEL_EN
        e.ae    = (m_level <= 2);
`else
        e.ae    = m_empty;
`endif
        e.addr  = 4'(m_rbin % 16);
        e.ptr   = bin2gray(m_rbin);
        e.valid = m_valid;
        e.err   = m_err;
        e.level = 5'(m_level);
        return e;
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, "_empty"}, 32'(empty), 32'd1);
        chk({tag, "_ae"}, 32'(almost_empty), 32'd1);
        chk({tag, "_ptr"}, 32'(rd_ptr), 32'd0);
        chk({tag, "_addr"}, 32'(rd_addr), 32'd0);
        chk({tag, "_valid"}, 32'(rd_valid), 32'd0);
        chk({tag, "_err"}, 32'(underflow_err), 32'd0);
`ifdef FIFO_RD_LEVEL_EN
        chk({tag, "_level"}, 32'(rd_level), 32'd0);
`endif
    endtask

    // Drive one cycle; expected values come from the table row or from the model.
    task automatic run_cycle(input logic ren, input logic clr, input logic [4:0] wptr,
                             input bit use_tbl, input exp_t tbl);
        exp_t e;
        exp_t got;
        logic acc;
        rd_en = ren; err_clr = clr; rq2_wptr = wptr;
        acc = ren & ~m_empty;
        if (ren & m_empty) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        m_rbin  = (m_rbin + int'(acc)) % 32;
        m_reads += int'(acc);
        m_valid = acc;
        m_empty = (gray2bin(wptr) == m_rbin);
        m_level = (gray2bin(wptr) - m_rbin + 32) % 32;
        e = model_exp();
        if (use_tbl) begin
            exp_t t;
            t = tbl;
`ifdef FIFO_RD_LEVEL_EN
            t.ae = e.ae;
            t.level = e.level;
`endif
            e = t;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        chk("empty", 32'(empty), 32'(got.empty));
        chk("almost_empty", 32'(almost_empty), 32'(got.ae));
        chk("rd_addr", 32'(rd_addr), 32'(got.addr));
        chk("rd_ptr", 32'(rd_ptr), 32'(got.ptr));
        chk("rd_valid", 32'(rd_valid), 32'(got.valid));
        chk("underflow_err", 32'(underflow_err), 32'(got.err));
`ifdef FIFO_RD_LEVEL_EN
        chk("rd_level", 32'(rd_level), 32'(got.level));
`endif
    endtask

    task automatic apply_reset();
        exp_t dummy;
        @(negedge clk);
        rst_n = 1'b0; rd_en = 1'b0; err_clr = 1'b0; rq2_wptr = '0;
        #1;
        model_reset();
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        dummy = model_exp();
    endtask

    function automatic exp_t mk(input logic em, input logic [3:0] a, input logic [4:0] p,
                                input logic v, input logic er);
        exp_t e;
        e.empty = em; e.ae = em; e.addr = a; e.ptr = p; e.valid = v; e.err = er; e.level = '0;
        return e;
    endfunction

    vec_t vecs[11];
    exp_t none;

    initial begin
        int   wbin;
        int   cyc;
        logic [4:0] prev_ptr;
        logic [3:0] prev_addr;
        bit   ptr_wrap;
        bit   addr_wrap;

        none = mk(1'b0, 4'd0, 5'd0, 1'b0, 1'b0);
        // drain 3 entries, underflow, then error-clear priority and one more fill/drain
        vecs[0]  = '{1'b0, 1'b0, 5'b00010, mk(1'b0, 4'd0, 5'b00000, 1'b0, 1'b0)};
        vecs[1]  = '{1'b1, 1'b0, 5'b00010, mk(1'b0, 4'd1, 5'b00001, 1'b1, 1'b0)};
        vecs[2]  = '{1'b1, 1'b0, 5'b00010, mk(1'b0, 4'd2, 5'b00011, 1'b1, 1'b0)};
        vecs[3]  = '{1'b1, 1'b0, 5'b00010, mk(1'b1, 4'd3, 5'b00010, 1'b1, 1'b0)};
        vecs[4]  = '{1'b1, 1'b0, 5'b00010, mk(1'b1, 4'd3, 5'b00010, 1'b0, 1'b1)};
        vecs[5]  = '{1'b1, 1'b1, 5'b00010, mk(1'b1, 4'd3, 5'b00010, 1'b0, 1'b1)};
        vecs[6]  = '{1'b0, 1'b1, 5'b00010, mk(1'b1, 4'd3, 5'b00010, 1'b0, 1'b0)};
        vecs[7]  = '{1'b0, 1'b0, 5'b00010, mk(1'b1, 4'd3, 5'b00010, 1'b0, 1'b0)};
        vecs[8]  = '{1'b0, 1'b0, 5'b00110, mk(1'b0, 4'd3, 5'b00010, 1'b0, 1'b0)};
        vecs[9]  = '{1'b1, 1'b0, 5'b00110, mk(1'b1, 4'd4, 5'b00110, 1'b1, 1'b0)};
        vecs[10] = '{1'b0, 1'b0, 5'b00110, mk(1'b1, 4'd4, 5'b00110, 1'b0, 1'b0)};

        m_reads = 0;
        apply_reset();
        foreach (vecs[i]) run_cycle(vecs[i].rd_en, vecs[i].clr, vecs[i].wptr, 1'b1, vecs[i].e);

        // long stream across the pointer wrap, write side kept ahead
        apply_reset();
        wbin = 0; m_reads = 0; cyc = 0;
        ptr_wrap = 1'b0; addr_wrap = 1'b0;
        prev_ptr = rd_ptr; prev_addr = rd_addr;
        while (m_reads < 40 && cyc < 400) begin
            if (((wbin - m_rbin + 32) % 32) < 16 && $urandom_range(0, 3) != 0)
                wbin = (wbin + 1) % 32;
            run_cycle(1'($urandom_range(0, 3) != 0), 1'b0, bin2gray(wbin), 1'b0, none);
            if (prev_ptr == 5'b10000 && rd_ptr == 5'b00000) ptr_wrap = 1'b1;
            if (prev_addr == 4'd15 && rd_addr == 4'd0) addr_wrap = 1'b1;
            prev_ptr = rd_ptr; prev_addr = rd_addr;
            cyc++;
        end
        chk("stream_budget", 32'(m_reads >= 40), 32'd1);
        chk("rd_ptr_wrap", 32'(ptr_wrap), 32'd1);
        chk("rd_addr_wrap", 32'(addr_wrap), 32'd1);

`ifdef FIFO_RD_LEVEL_EN
        apply_reset();
        run_cycle(1'b0, 1'b0, 5'b01111, 1'b0, none);
        chk("level10", 32'(rd_level), 32'd10);
        chk("level10_ae", 32'(almost_empty), 32'd0);
        for (int i = 0; i < 8; i++) run_cycle(1'b1, 1'b0, 5'b01111, 1'b0, none);
        chk("level2", 32'(rd_level), 32'd2);
        chk("level2_ae", 32'(almost_empty), 32'd1);
        for (int i = 0; i < 2; i++) run_cycle(1'b1, 1'b0, 5'b01111, 1'b0, none);
        chk("level0", 32'(rd_level), 32'd0);
        chk("level0_empty", 32'(empty), 32'd1);
`endif

        // async reset pulsed between clock edges during a read burst
        apply_reset();
        run_cycle(1'b0, 1'b0, bin2gray(8), 1'b0, none);
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0, bin2gray(8), 1'b0, none);
        chk("burst_addr", 32'(rd_addr), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_cycle(1'b1, 1'b0, bin2gray(2), 1'b0, none);
        run_cycle(1'b1, 1'b0, bin2gray(2), 1'b0, none);
        run_cycle(1'b1, 1'b0, bin2gray(2), 1'b0, none);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
